// File: rtl/sdf_march_scheduler.sv
// Ray-march scheduler: time-shares one fixed-latency pipelined SDF unit across SLOTS ray contexts.
// Q16.16 fixed point throughout; vec3 buses pack {z, y, x}, 32 bits per component.
module sdf_march_scheduler #(
   parameter int unsigned  SLOTS       = 4,
   parameter int unsigned  SDF_LATENCY = 3,
   parameter int unsigned  ID_W        = 16,
   parameter int unsigned  MAX_STEPS   = 64,
   parameter logic [31:0]  HIT_EPS     = 32'h0000_0100,
   parameter logic [31:0]  MAX_DIST    = 32'h0040_0000,
   localparam int unsigned FP_W        = 32,
   localparam int unsigned VEC_W       = 3 * FP_W,
   localparam int unsigned STEP_W      = $clog2(MAX_STEPS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ray_valid,
   output logic              ray_ready,
   input  logic [VEC_W-1:0]  ray_origin,
   input  logic [VEC_W-1:0]  ray_dir,
   input  logic [ID_W-1:0]   ray_id,
   output logic              sdf_valid_in,
   output logic [VEC_W-1:0]  sdf_point,
   input  logic              sdf_valid_out,
   input  logic [FP_W-1:0]   sdf_distance,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ID_W-1:0]   res_id,
   output logic [FP_W-1:0]   res_t,
   output logic              res_hit,
   output logic [STEP_W-1:0] res_steps,
   output logic              err
);
   localparam int unsigned SW    = $clog2(SLOTS);
   localparam int unsigned DEPTH = SDF_LATENCY + 1;
   localparam int unsigned FRAC  = 16;

   typedef enum logic [1:0] {S_FREE, S_READY, S_WAIT, S_DONE} slot_state_t;

   slot_state_t       state     [SLOTS];
   slot_state_t       state_nxt [SLOTS];
   logic [VEC_W-1:0]  origin    [SLOTS];
   logic [VEC_W-1:0]  dir       [SLOTS];
   logic [ID_W-1:0]   id        [SLOTS];
   logic [FP_W-1:0]   t         [SLOTS];
   logic [STEP_W-1:0] steps     [SLOTS];
   logic [SLOTS-1:0]  hit;

   logic [SW-1:0]     issue_ptr, out_ptr, out_slot;
   logic [DEPTH-1:0]  tag_v;
   logic [SW-1:0]     tag_s [DEPTH];

   logic              free_found, accept, grant, ret_v, ret_hit, ret_miss, take, sel_found, sel;
   logic [SW-1:0]     free_idx, gnt_idx, ret_s, sel_idx, cand;
   logic [FP_W-1:0]   t_sum;
   logic [STEP_W-1:0] steps_sum;
   logic [VEC_W-1:0]  point;

   function automatic logic [FP_W-1:0] fp_mul(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
      logic signed [2*FP_W-1:0] p;
      p = (2*FP_W)'($signed(a)) * (2*FP_W)'($signed(b));
      return FP_W'(p >>> FRAC);
   endfunction

   // Slot selection: lowest FREE for accept, round-robin READY for issue, round-robin DONE for output.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      grant      = 1'b0;
      gnt_idx    = '0;
      sel_found  = 1'b0;
      sel_idx    = '0;
      cand       = '0;
      point      = '0;
      take       = res_valid && res_ready;
      for (int i = 0; i < SLOTS; i++) begin
         if (!free_found && state[i] == S_FREE) begin
            free_found = 1'b1;
            free_idx   = SW'(i);
         end
      end
      for (int i = 0; i < SLOTS; i++) begin
         cand = issue_ptr + SW'(i);
         if (!grant && state[cand] == S_READY) begin
            grant   = 1'b1;
            gnt_idx = cand;
         end
      end
      for (int i = 0; i < SLOTS; i++) begin
         cand = out_ptr + SW'(i);
         if (!sel_found && state[cand] == S_DONE && !(take && cand == out_slot)) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
      sel       = sel_found && (!res_valid || take);
      ray_ready = free_found && !rst;
      accept    = ray_valid && ray_ready;
      for (int k = 0; k < 3; k++) begin
         point[k*FP_W +: FP_W] = origin[gnt_idx][k*FP_W +: FP_W]
                               + fp_mul(t[gnt_idx], dir[gnt_idx][k*FP_W +: FP_W]);
      end
      ret_v     = tag_v[DEPTH-1];
      ret_s     = tag_s[DEPTH-1];
      t_sum     = t[ret_s] + sdf_distance;
      steps_sum = steps[ret_s] + STEP_W'(1);
      ret_hit   = $signed(sdf_distance) < $signed(HIT_EPS);
      ret_miss  = ($signed(t_sum) >= $signed(MAX_DIST)) || (steps_sum == STEP_W'(MAX_STEPS));
   end

   // Per-slot next state; the four events always target slots in distinct states.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) state_nxt[i] = state[i];
      if (accept) state_nxt[free_idx] = S_READY;
      if (grant)  state_nxt[gnt_idx]  = S_WAIT;
      if (ret_v)  state_nxt[ret_s]    = (ret_hit || ret_miss) ? S_DONE : S_READY;
      if (take)   state_nxt[out_slot] = S_FREE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SLOTS; i++) begin
            state[i]  <= S_FREE;
            origin[i] <= '0;
            dir[i]    <= '0;
            id[i]     <= '0;
            t[i]      <= '0;
            steps[i]  <= '0;
         end
         for (int i = 0; i < DEPTH; i++) tag_s[i] <= '0;
         hit          <= '0;
         tag_v        <= '0;
         issue_ptr    <= '0;
         out_ptr      <= '0;
         out_slot     <= '0;
         sdf_valid_in <= 1'b0;
         sdf_point    <= '0;
         res_valid    <= 1'b0;
         res_id       <= '0;
         res_t        <= '0;
         res_hit      <= 1'b0;
         res_steps    <= '0;
         err          <= 1'b0;
      end else begin
         for (int i = 0; i < SLOTS; i++) state[i] <= state_nxt[i];
         if (accept) begin
            origin[free_idx] <= ray_origin;
            dir[free_idx]    <= ray_dir;
            id[free_idx]     <= ray_id;
            t[free_idx]      <= '0;
            steps[free_idx]  <= '0;
         end
         sdf_valid_in <= grant;
         if (grant) begin
            sdf_point <= point;
            issue_ptr <= gnt_idx + SW'(1);
         end
         // Tag pipe mirrors the SDF latency so each return is routed to its issuing slot.
         tag_v    <= {tag_v[DEPTH-2:0], grant};
         tag_s[0] <= gnt_idx;
         for (int i = 1; i < DEPTH; i++) tag_s[i] <= tag_s[i-1];
         if (ret_v) begin
            steps[ret_s] <= steps_sum;
            hit[ret_s]   <= ret_hit;
            if (!ret_hit) t[ret_s] <= t_sum;
            if (!sdf_valid_out) err <= 1'b1;
         end
         if (sel) begin
            res_valid <= 1'b1;
            res_id    <= id[sel_idx];
            res_t     <= t[sel_idx];
            res_hit   <= hit[sel_idx];
            res_steps <= steps[sel_idx];
            out_slot  <= sel_idx;
            out_ptr   <= sel_idx + SW'(1);
         end else if (take) begin
            res_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sdf_march_scheduler.sv
// Self-checking bench for sdf_march_scheduler with a latency-3 SDF model and an id-keyed result scoreboard.
`timescale 1ns/1ps
module tb_sdf_march_scheduler;
   localparam logic [31:0] ONE = 32'h0001_0000;
   localparam logic [31:0] NEG = 32'hFFFF_0000;

   logic        clk = 1'b0, rst = 1'b1;
   logic        ray_valid = 1'b0, ray_ready;
   logic [95:0] ray_origin = '0, ray_dir = '0;
   logic [15:0] ray_id = '0;
   logic        sdf_valid_in, sdf_valid_out;
   logic [95:0] sdf_point;
   logic [31:0] sdf_distance;
   logic        res_valid, res_ready = 1'b1, res_hit, err;
   logic [15:0] res_id;
   logic [31:0] res_t;
   logic [6:0]  res_steps;

   sdf_march_scheduler dut (
      .clk(clk), .rst(rst), .ray_valid(ray_valid), .ray_ready(ray_ready),
      .ray_origin(ray_origin), .ray_dir(ray_dir), .ray_id(ray_id),
      .sdf_valid_in(sdf_valid_in), .sdf_point(sdf_point),
      .sdf_valid_out(sdf_valid_out), .sdf_distance(sdf_distance),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_t(res_t),
      .res_hit(res_hit), .res_steps(res_steps), .err(err)
   );

   always #5 clk = ~clk;

   // SDF model: mode 0 is the plane d = 2.0 - z, mode 1 is constant 0.5; three-cycle latency.
   int          mode = 0;
   logic [2:0]  mv = '0;
   logic [31:0] md [3] = '{default: '0};
   always @(posedge clk) begin
      mv    <= {mv[1:0], sdf_valid_in};
      md[0] <= (mode == 0) ? (32'h0002_0000 - sdf_point[95:64]) : 32'h0000_8000;
      md[1] <= md[0];
      md[2] <= md[1];
   end
   assign sdf_valid_out = mv[2];
   assign sdf_distance  = md[2];

   int n_pass = 0, n_total = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [15:0] id;
      logic        hit;
      logic [31:0] t;
      logic [6:0]  steps;
   } res_exp_t;
   res_exp_t sbq[$];

   int cyc = 0, hs_count = 0, acc_hs = 0;
   int log_c[$];
   logic [31:0] log_x[$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (sdf_valid_in) begin
      log_c.push_back(cyc);
      log_x.push_back(sdf_point[31:0]);
   end

   // Scoreboard: every handshaken result must match an outstanding expected record by id.
   always @(negedge clk) begin
      int idx;
      if (!rst && res_valid && res_ready) begin
         hs_count++;
         idx = -1;
         for (int i = 0; i < sbq.size(); i++) if (sbq[i].id == res_id) idx = i;
         if (idx < 0) begin
            n_total++;
            $display("FAIL res_id: got unexpected id 0x%0h, expected one of %0d outstanding", res_id, sbq.size());
         end else begin
            chk($sformatf("res_hit id%0h", res_id), res_hit, sbq[idx].hit);
            chk($sformatf("res_t id%0h", res_id), res_t, sbq[idx].t);
            chk($sformatf("res_steps id%0h", res_id), res_steps, sbq[idx].steps);
            sbq.delete(idx);
         end
      end
   end

   function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return {z, y, x};
   endfunction

   // Called at posedge+1; the ray is accepted at the first posedge with ray_ready high.
   task automatic send_ray(input logic [95:0] o, input logic [95:0] d, input logic [15:0] rid,
                           input logic eh, input logic [31:0] et, input logic [6:0] es, input bit push);
      int n = 0;
      ray_origin = o; ray_dir = d; ray_id = rid; ray_valid = 1'b1;
      @(negedge clk);
      while (!ray_ready && n < 2000) begin @(negedge clk); n++; end
      if (!ray_ready) begin
         n_total++;
         $display("FAIL ray_accept id%0h: got no ray_ready within %0d cycles, expected accept", rid, n);
      end else begin
         acc_hs = hs_count;
         if (push) sbq.push_back('{rid, eh, et, es});
      end
      @(posedge clk); #1 ray_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sbq.size() != 0 && n < 3000) begin @(posedge clk); n++; end
      #1;
      if (sbq.size() != 0) begin
         n_total++;
         $display("FAIL %s: got %0d results outstanding after timeout, expected 0", name, sbq.size());
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   typedef struct {
      logic [95:0] o, d;
      logic [15:0] id;
      int          mode;
      logic        hit;
      logic [31:0] t;
      logic [6:0]  steps;
   } vec_t;
   vec_t vt[8];

   initial begin
      int n, hs_before, rid;
      logic [63:0] snap;
      bit seen_valid, seen_err;

      vt[0] = '{v3(0, 0, 0),          v3(0, 0, ONE),          16'h11, 0, 1'b1, 32'h0002_0000, 7'd2};
      vt[1] = '{v3(0, 0, 0),          v3(0, 0, NEG),          16'h12, 0, 1'b0, 32'h007E_0000, 7'd6};
      vt[2] = '{v3(0, 0, 0),          v3(0, 0, ONE),          16'h13, 1, 1'b0, 32'h0020_0000, 7'd64};
      vt[3] = '{v3(0, 0, ONE),        v3(0, 0, ONE),          16'h14, 0, 1'b1, 32'h0001_0000, 7'd2};
      vt[4] = '{v3(0, 0, 32'h0003_0000), v3(0, 0, ONE),       16'h15, 0, 1'b1, 32'h0000_0000, 7'd1};
      vt[5] = '{v3(0, 0, 32'hFFC2_0000), v3(0, 0, NEG),       16'h16, 0, 1'b0, 32'h0040_0000, 7'd1};
      vt[6] = '{v3(0, 0, 0),          v3(0, 0, 32'h0000_8000), 16'h17, 0, 1'b1, 32'h0003_FF00, 7'd11};
      vt[7] = '{v3(32'h0007_0000, NEG, 0), v3(0, 0, ONE),     16'h18, 0, 1'b1, 32'h0002_0000, 7'd2};

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst ray_ready", ray_ready, 0);
      chk("rst sdf_valid_in", sdf_valid_in, 0);
      chk("rst res_valid", res_valid, 0);
      chk("rst err", err, 0);
      chk("rst sdf_point", sdf_point, 0);
      chk("rst res_id", res_id, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post-rst ray_ready", ray_ready, 1);
      @(posedge clk); #1;

      // Single-ray vectors, one at a time.
      for (int i = 0; i < 8; i++) begin
         mode = vt[i].mode;
         send_ray(vt[i].o, vt[i].d, vt[i].id, vt[i].hit, vt[i].t, vt[i].steps, 1'b1);
         drain($sformatf("vec%0d", i));
      end
      mode = 0;

      // Four back-to-back rays, then a fifth that must wait for a slot to free.
      do_reset();
      log_c.delete(); log_x.delete();
      for (int i = 0; i < 4; i++)
         send_ray(v3(32'(i) << 16, 0, 0), v3(0, 0, ONE), 16'(16'h21 + i), 1'b1, 32'h0002_0000, 7'd2, 1'b1);
      @(negedge clk);
      chk("ray_ready after 4 accepts", ray_ready, 0);
      repeat (4) @(negedge clk);
      if (log_x.size() < 4) begin
         n_total++;
         $display("FAIL issue log: got %0d issues, expected at least 4", log_x.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("issue%0d point.x", i), log_x[i], 64'(i) << 16);
            chk($sformatf("issue%0d cycle", i), 64'(log_c[i] - log_c[0]), 64'(i));
         end
      end
      @(posedge clk); #1;
      hs_before = hs_count;
      send_ray(v3(0, 0, 0), v3(0, 0, ONE), 16'h25, 1'b1, 32'h0002_0000, 7'd2, 1'b1);
      chk("5th accept after handshake", acc_hs > hs_before, 1);
      drain("five rays");

      // Two DONE slots held behind res_ready=0, then released back-to-back.
      res_ready = 1'b0;
      send_ray(v3(0, 0, 0), v3(0, 0, ONE), 16'h31, 1'b1, 32'h0002_0000, 7'd2, 1'b1);
      send_ray(v3(0, 0, 0), v3(0, 0, ONE), 16'h32, 1'b1, 32'h0002_0000, 7'd2, 1'b1);
      n = 0;
      while (!res_valid && n < 100) begin @(negedge clk); n++; end
      chk("hold res_valid", res_valid, 1);
      repeat (8) @(negedge clk);
      snap = {res_id, res_t, res_hit, res_steps};
      rid = int'(res_id);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("hold stable c%0d", i), {res_valid, res_id, res_t, res_hit, res_steps}, {1'b1, snap[55:0]});
      end
      @(posedge clk); #1 res_ready = 1'b1;
      @(negedge clk);
      chk("release first id", res_id, 64'(rid));
      @(negedge clk);
      chk("release second res_valid", res_valid, 1);
      @(posedge clk); #1;
      drain("hold pair");
      @(negedge clk);
      chk("idle res_valid", res_valid, 0);
      @(posedge clk); #1;

      // Reset with three rays in WAIT: late returns must be dropped.
      send_ray(v3(0, 0, 0), v3(0, 0, ONE), 16'h41, 1'b1, 32'h0002_0000, 7'd2, 1'b0);
      send_ray(v3(0, 0, 0), v3(0, 0, ONE), 16'h42, 1'b1, 32'h0002_0000, 7'd2, 1'b0);
      send_ray(v3(0, 0, 0), v3(0, 0, ONE), 16'h43, 1'b1, 32'h0002_0000, 7'd2, 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("ray_ready during rst", ray_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      seen_valid = 1'b0; seen_err = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (res_valid) seen_valid = 1'b1;
         if (err) seen_err = 1'b1;
      end
      chk("no result after rst", seen_valid, 0);
      chk("err after rst", seen_err, 0);
      @(posedge clk); #1;
      send_ray(v3(0, 0, ONE), v3(0, 0, ONE), 16'h44, 1'b1, 32'h0001_0000, 7'd2, 1'b1);
      drain("post-rst ray");
      @(negedge clk);
      chk("final err", err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout at %0t, expected bench completion", $time);
      $fatal(1, "watchdog");
   end
endmodule
